// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default widths for the memory arbiter.
//   state_t : arbiter FSM states (IDLE / REQ / RESP)
//   owner_t : which requester owns the transaction in flight
package mem_arb_pkg;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant -- combinational winner selection between fetch and data.
// Ports:
//   if_valid, d_valid : request valids from the two requesters
//   starved           : fetch has lost too often; fetch wins if it is waiting
//   grant             : some requester wins this cycle
//   winner            : which requester wins (meaningful only when grant=1)
import mem_arb_pkg::*;

module mem_arb_grant (
   input  logic   if_valid,
   input  logic   d_valid,
   input  logic   starved,
   output logic   grant,
   output owner_t winner
);

   always_comb begin
      grant  = 1'b0;
      winner = OWN_IF;
      if (if_valid && (starved || !d_valid)) begin
         grant  = 1'b1;
         winner = OWN_IF;
      end else if (d_valid) begin
         grant  = 1'b1;
         winner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported memory between an instruction
// fetch requester and a data requester, one transaction outstanding at a time.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   if_req_valid/ready, if_addr   : fetch request (read only)
//   if_resp_valid, if_rdata       : fetch response (one-cycle pulse, data held)
//   d_req_valid/ready, d_we, d_addr, d_wdata, d_wstrb : data request
//   d_resp_valid, d_rdata         : data response (one-cycle pulse, data held)
//   mem_req/gnt, mem_we, mem_addr, mem_wdata, mem_wstrb : memory request side
//   mem_rvalid, mem_rdata         : memory completion (reads and writes)
// Build option: MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard;
// without it data has strict priority.
//
// FSM states:
//   state | meaning
//   IDLE  | arbitrate; winner's ready is high, accept on valid
//   REQ   | mem_req high with captured fields, wait for mem_gnt
//   RESP  | wait for mem_rvalid, then pulse owner's resp_valid
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t state;
   owner_t owner;
   owner_t winner;
   logic   grant;
   logic   starved;

   mem_arb_grant u_grant (
      .if_valid (if_req_valid),
      .d_valid  (d_req_valid),
      .starved  (starved),
      .grant    (grant),
      .winner   (winner)
   );

   assign if_req_ready = (state == IDLE) && grant && (winner == OWN_IF);
   assign d_req_ready  = (state == IDLE) && grant && (winner == OWN_D);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   assign starved = (starve_cnt >= LIMIT);

   // Counts data wins that happened while fetch was waiting; saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (state == IDLE && grant) begin
         if (winner == OWN_IF) begin
            starve_cnt <= '0;
         end else if (if_req_valid && starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end
`else
   assign starved = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= OWN_IF;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         if_resp_valid <= 1'b0;
         d_resp_valid  <= 1'b0;
         if_rdata      <= '0;
         d_rdata       <= '0;
      end else begin
         if_resp_valid <= 1'b0;
         d_resp_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner   <= winner;
                  mem_req <= 1'b1;
                  state   <= REQ;
                  if (winner == OWN_D) begin
                     mem_addr  <= d_addr;
                     mem_we    <= d_we;
                     mem_wdata <= d_wdata;
                     mem_wstrb <= d_wstrb;
                  end else begin
                     mem_addr  <= if_addr;
                     mem_we    <= 1'b0;
                     mem_wdata <= '0;
                     mem_wstrb <= '0;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid) begin
                  state <= IDLE;
                  if (owner == OWN_D) begin
                     d_resp_valid <= 1'b1;
                     d_rdata      <= mem_rdata;
                  end else begin
                     if_resp_valid <= 1'b1;
                     if_rdata      <= mem_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter. Expected responses are
// queued when a request is accepted and checked by an independent monitor.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int n_tests = 0;
   int n_fail  = 0;

   // {owner (1 = data), rdata}
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response cycle must match the oldest expected response.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (if_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_resp", {30'd0, d_resp_valid, if_resp_valid}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("mon_if_resp_valid", {31'd0, if_resp_valid}, {31'd0, !e[32]});
               chk("mon_d_resp_valid", {31'd0, d_resp_valid}, {31'd0, e[32]});
               chk("mon_rdata", e[32] ? d_rdata : if_rdata, e[31:0]);
            end
         end
      end
   end

   // Caller has already driven the request inputs; this runs one transaction.
   task automatic txn(input bit own_d, input bit drop, input logic [31:0] e_addr,
                      input bit e_we, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                      input int gnt_dly, input logic [31:0] rd);
      #1;
      chk("accept_if_ready", {31'd0, if_req_ready}, {31'd0, !own_d});
      chk("accept_d_ready", {31'd0, d_req_ready}, {31'd0, own_d});
      sb_q.push_back({own_d, rd});
      tick();
      if (drop) begin
         if (own_d) d_req_valid = 1'b0;
         else       if_req_valid = 1'b0;
      end
      for (int i = 0; i <= gnt_dly; i++) begin
         chk("req_mem_req", {31'd0, mem_req}, 32'd1);
         chk("req_mem_addr", mem_addr, e_addr);
         chk("req_mem_we", {31'd0, mem_we}, {31'd0, e_we});
         chk("req_mem_wdata", mem_wdata, e_wdata);
         chk("req_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
         chk("req_readies_low", {30'd0, if_req_ready, d_req_ready}, 32'd0);
         if (i == gnt_dly) mem_gnt = 1'b1;
         tick();
      end
      mem_gnt = 1'b0;
      chk("resp_mem_req_low", {31'd0, mem_req}, 32'd0);
      chk("resp_readies_low", {30'd0, if_req_ready, d_req_ready}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk("lat_if_resp_valid", {31'd0, if_resp_valid}, {31'd0, !own_d});
      chk("lat_d_resp_valid", {31'd0, d_resp_valid}, {31'd0, own_d});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      if_req_valid = 1'b0; if_addr = 32'h0;
      d_req_valid = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      chk("rst_resp_valids", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_readies", {30'd0, if_req_ready, d_req_ready}, 32'd0);

      // Stray handshakes while idle must be ignored.
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      chk("stray_resp", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
      chk("stray_if_rdata", if_rdata, 32'd0);

      // Single fetch, minimum latency.
      if_addr = 32'h100; if_req_valid = 1'b1;
      txn(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
      chk("fetch_if_rdata", if_rdata, 32'hDEAD_BEEF);
      chk("fetch_d_rdata", d_rdata, 32'h0);

      // Simultaneous requests: data first, then fetch back-to-back.
      d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wstrb = 4'hF; d_req_valid = 1'b1;
      if_addr = 32'h104; if_req_valid = 1'b1;
      txn(1'b1, 1'b1, 32'h200, 1'b1, 32'h1234_5678, 4'hF, 0, 32'hA5A5_0001);
      txn(1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D);
      chk("hold_d_rdata", d_rdata, 32'hA5A5_0001);
      chk("new_if_rdata", if_rdata, 32'h0BAD_F00D);

      // Grant withheld for 5 cycles on a data read.
      d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h55; d_wstrb = 4'h3; d_req_valid = 1'b1;
      txn(1'b1, 1'b1, 32'h300, 1'b0, 32'h55, 4'h3, 5, 32'hCAFE_0003);
      chk("hold_if_rdata", if_rdata, 32'h0BAD_F00D);
      chk("wait_d_rdata", d_rdata, 32'hCAFE_0003);

      // Reset while waiting for completion drops the transaction.
      if_addr = 32'h180; if_req_valid = 1'b1;
      #1;
      chk("rt_if_ready", {31'd0, if_req_ready}, 32'd1);
      tick();
      if_req_valid = 1'b0;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rt_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rt_resp", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      chk("rt_late_resp", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
      chk("rt_if_rdata", if_rdata, 32'd0);
      chk("rt_d_rdata", d_rdata, 32'd0);
      if_addr = 32'h1C0; if_req_valid = 1'b1;
      txn(1'b0, 1'b1, 32'h1C0, 1'b0, 32'h0, 4'h0, 0, 32'h600D_0001);
      chk("rt_after_if_rdata", if_rdata, 32'h600D_0001);

      // Continuous contention from both requesters.
      d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h1111_2222; d_wstrb = 4'hC; d_req_valid = 1'b1;
      if_addr = 32'h500; if_req_valid = 1'b1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            txn(1'b1, 1'b0, 32'h400, 1'b1, 32'h1111_2222, 4'hC, 0, 32'h1000 + 32'(r * 8 + k));
         txn(1'b0, 1'b0, 32'h500, 1'b0, 32'h0, 4'h0, 0, 32'h2000 + 32'(r));
      end
`else
      for (int k = 0; k < 10; k++)
         txn(1'b1, 1'b0, 32'h400, 1'b1, 32'h1111_2222, 4'hC, 0, 32'h1000 + 32'(k));
`endif
      d_req_valid = 1'b0;
      if_req_valid = 1'b0;
      repeat (3) tick();
      chk("end_mem_req", {31'd0, mem_req}, 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
